// File: rtl/uart_controller.sv
// uart_controller: memory-mapped 8N1 UART with TX/RX FIFOs, programmable baud divisor and level interrupt.
module uart_controller #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [3:0]  be_i,
  input  logic [14:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  input  logic        rx_i,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic        r_tx_en, r_rx_en, r_ie_rx, r_ie_tx, r_overrun, r_frame_err, r_irq, r_tx_o;
  logic [15:0] r_baud_div, r_tx_cnt, r_tx_div, r_rx_cnt, r_rx_div;
  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [7:0]  r_rx_mem [FIFO_DEPTH];
  logic [AW:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [7:0]  r_tx_sh, r_rx_sh;
  logic [2:0]  r_tx_bit, r_rx_bit, r_rx_sync;
  state_t      r_tx_st, r_rx_st;
  logic        w_sel_ctrl, w_sel_stat, w_sel_txd, w_sel_rxd, w_wr_ctrl, w_wr_stat;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic        w_tx_end, w_rx_tick, w_rx, w_rx_fall, w_rx_stop, w_set_ovr, w_set_fe, w_unused;
  logic [15:0] w_div;
  assign w_sel_ctrl = addr_i[10:2] == 9'd0;
  assign w_sel_stat = addr_i[10:2] == 9'd1;
  assign w_sel_txd  = addr_i[10:2] == 9'd2;
  assign w_sel_rxd  = addr_i[10:2] == 9'd3;
  assign w_wr_ctrl  = we_i & w_sel_ctrl;
  assign w_wr_stat  = we_i & w_sel_stat & be_i[0];
  assign w_unused   = ^{addr_i[14:11], addr_i[1:0], be_i[1], wdata_i[15:8]};
  assign w_div      = (r_baud_div < 16'd2) ? 16'd2 : r_baud_div;
  assign w_tx_empty = r_tx_wp == r_tx_rp;
  assign w_rx_empty = r_rx_wp == r_rx_rp;
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_tx_end   = (r_tx_st != IDLE) && (r_tx_cnt == r_tx_div - 16'd1);
  assign w_tx_pop   = r_tx_en & ~w_tx_empty & ((r_tx_st == IDLE) | ((r_tx_st == STOP) & w_tx_end));
  assign w_tx_push  = we_i & w_sel_txd & be_i[0] & (~w_tx_full | w_tx_pop);
  assign w_rx       = r_rx_sync[1];
  assign w_rx_fall  = r_rx_sync[2] & ~r_rx_sync[1];
  // START samples mid-bit; later states sample a full bit period after the previous sample
  assign w_rx_tick  = (r_rx_st == START) ? (r_rx_cnt == (r_rx_div >> 1) - 16'd1)
                    : (r_rx_st != IDLE) && (r_rx_cnt == r_rx_div - 16'd1);
  assign w_rx_stop  = r_rx_en & (r_rx_st == STOP) & w_rx_tick;
  assign w_rx_pop   = re_i & w_sel_rxd & ~w_rx_empty;
  assign w_rx_push  = w_rx_stop & w_rx & (~w_rx_full | w_rx_pop);
  assign w_set_ovr  = w_rx_stop & w_rx & w_rx_full & ~w_rx_pop;
  assign w_set_fe   = w_rx_stop & ~w_rx;
  assign tx_o       = r_tx_o;
  assign irq_o      = r_irq;
  assign rdata_o    = w_sel_ctrl ? {r_baud_div, 12'd0, r_ie_tx, r_ie_rx, r_rx_en, r_tx_en}
                    : w_sel_stat ? {26'd0, r_frame_err, r_overrun, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full}
                    : w_sel_rxd  ? {23'd0, ~w_rx_empty, r_rx_mem[r_rx_rp[AW-1:0]]} : 32'd0;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      {r_ie_tx, r_ie_rx, r_rx_en, r_tx_en} <= 4'd0;
      r_baud_div <= 16'(DEFAULT_DIV);
      r_overrun <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq <= 1'b0;
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_wr_ctrl && be_i[0]) {r_ie_tx, r_ie_rx, r_rx_en, r_tx_en} <= wdata_i[3:0];
      if (w_wr_ctrl && be_i[2]) r_baud_div[7:0] <= wdata_i[23:16];
      if (w_wr_ctrl && be_i[3]) r_baud_div[15:8] <= wdata_i[31:24];
      r_overrun <= w_set_ovr | (r_overrun & ~(w_wr_stat & wdata_i[4]));
      r_frame_err <= w_set_fe | (r_frame_err & ~(w_wr_stat & wdata_i[5]));
      r_irq <= (r_ie_rx & ~w_rx_empty) | (r_ie_tx & w_tx_empty) | r_overrun | r_frame_err;
      r_tx_wp <= r_tx_wp + {{AW{1'b0}}, w_tx_push};
      r_tx_rp <= r_tx_rp + {{AW{1'b0}}, w_tx_pop};
      r_rx_wp <= r_rx_wp + {{AW{1'b0}}, w_rx_push};
      r_rx_rp <= r_rx_rp + {{AW{1'b0}}, w_rx_pop};
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= wdata_i[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_sh;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_tx_st <= IDLE;
      r_tx_o <= 1'b1;
      r_tx_cnt <= '0;
      r_tx_div <= 16'd2;
      r_tx_bit <= '0;
      r_tx_sh <= '0;
    end else begin
      r_tx_cnt <= (r_tx_st == IDLE || w_tx_end) ? 16'd0 : r_tx_cnt + 16'd1;
      if (w_tx_pop) begin
        r_tx_st <= START;
        r_tx_o <= 1'b0;
        r_tx_sh <= r_tx_mem[r_tx_rp[AW-1:0]];
        r_tx_div <= w_div;
      end else if (w_tx_end) begin
        case (r_tx_st)
          START: begin
            r_tx_st <= DATA;
            r_tx_o <= r_tx_sh[0];
            r_tx_bit <= '0;
          end
          DATA: begin
            r_tx_st <= (r_tx_bit == 3'd7) ? STOP : DATA;
            r_tx_o <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_sh[1];
            r_tx_sh <= r_tx_sh >> 1;
            r_tx_bit <= r_tx_bit + 3'd1;
          end
          default: r_tx_st <= IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rx_sync <= 3'b111;
      r_rx_st <= IDLE;
      r_rx_cnt <= '0;
      r_rx_div <= 16'd2;
      r_rx_bit <= '0;
      r_rx_sh <= '0;
    end else begin
      r_rx_sync <= {r_rx_sync[1:0], rx_i};
      r_rx_cnt <= (r_rx_st == IDLE || w_rx_tick) ? 16'd0 : r_rx_cnt + 16'd1;
      if (!r_rx_en) r_rx_st <= IDLE;
      else case (r_rx_st)
        IDLE: if (w_rx_fall) begin
          r_rx_st <= START;
          r_rx_div <= w_div;
        end
        START: if (w_rx_tick) begin
          r_rx_st <= w_rx ? IDLE : DATA;
          r_rx_bit <= '0;
        end
        DATA: if (w_rx_tick) begin
          r_rx_sh <= {w_rx, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_st <= STOP;
        end
        default: if (w_rx_tick) r_rx_st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller: directed and randomized checks of uart_controller against a queue-based model.
module tb_uart_controller;
  logic        clk = 1'b0, rst = 1'b0, we = 1'b0, re = 1'b0, lb = 1'b0, rx_drv = 1'b1;
  logic [3:0]  be = 4'd0;
  logic [14:0] addr = 15'd0;
  logic [31:0] wdata = 32'd0, rdata, d;
  logic        tx, rx, irq, m_ovr = 1'b0, m_fe = 1'b0;
  logic [7:0]  rq[$], tq[$], b;
  logic [9:0]  fr;
  int          errors = 0, checks = 0, n;
  assign rx = lb ? tx : rx_drv;
  always #5 clk = ~clk;
  uart_controller dut (.clk_i(clk), .rst_i(rst), .we_i(we), .re_i(re), .be_i(be), .addr_i(addr),
                       .wdata_i(wdata), .rdata_o(rdata), .tx_o(tx), .rx_i(rx), .irq_o(irq));
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [10:0] a, input logic [31:0] v, input logic [3:0] m);
    addr = {4'b1000, a};
    wdata = v;
    be = m;
    we = 1'b1;
    tick();
    we = 1'b0;
    be = 4'd0;
  endtask
  task automatic rd(input logic [10:0] a, output logic [31:0] v);
    addr = {4'b1000, a};
    re = 1'b1;
    #1 v = rdata;
    tick();
    re = 1'b0;
  endtask
  // expected STATUS from the model: sticky flags plus RX queue occupancy
  function automatic logic [31:0] st(input logic txe, input logic txf);
    return {26'd0, m_fe, m_ovr, rq.size() == 0, rq.size() == 8, txe, txf};
  endfunction
  function automatic void model_rx(input logic [7:0] v, input logic stop);
    if (!stop) m_fe = 1'b1;
    else if (rq.size() < 8) rq.push_back(v);
    else m_ovr = 1'b1;
  endfunction
  task automatic send_frame(input logic [7:0] v, input logic stop, input int div);
    rx_drv = 1'b0;
    tick(div);
    for (int i = 0; i < 8; i++) begin
      rx_drv = v[i];
      tick(div);
    end
    rx_drv = stop;
    tick(div);
    rx_drv = 1'b1;
    model_rx(v, stop);
  endtask
  // decode one frame off tx by mid-bit sampling; waited = idle cycles before the start bit
  task automatic tx_cap(input int div, output logic [7:0] v, output int waited);
    waited = 0;
    while (tx !== 1'b0 && waited < 50 * div) begin
      tick();
      waited++;
    end
    chk("tx_start_seen", {31'd0, tx}, 32'd0);
    tick(div / 2);
    chk("tx_start_mid", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(div);
      v[i] = tx;
    end
    tick(div);
    chk("tx_stop", {31'd0, tx}, 32'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tick(3);
    rst = 1'b1;
    rd(11'h004, d); chk("rst_status", d, 32'h0000000A);
    rd(11'h000, d); chk("rst_ctrl", d, 32'h03640000);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(11'h010, d); chk("unmapped_rd", d, 32'd0);
    rd(11'h008, d); chk("txdata_rd", d, 32'd0);
    wr(11'h000, 32'hFFFF_0001, 4'b0001);
    rd(11'h000, d); chk("ctrl_be0", d, 32'h03640001);
    wr(11'h000, 32'h0004_0001, 4'hF);
    rd(11'h000, d); chk("ctrl_full", d, 32'h00040001);
    fr = {1'b1, 8'hA5, 1'b0};
    wr(11'h008, 32'h0000_00A5, 4'h1);
    n = 0;
    while (tx !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    chk("a5_start", {31'd0, tx}, 32'd0);
    for (int k = 1; k < 40; k++) begin
      tick();
      chk("a5_bit", {31'd0, tx}, {31'd0, fr[k / 4]});
    end
    tick();
    chk("a5_idle", {31'd0, tx}, 32'd1);
    rd(11'h004, d); chk("a5_status", d, st(1'b1, 1'b0));
    wr(11'h000, 32'h0004_0000, 4'hF);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (tq.size() < 8) tq.push_back(b);
      wr(11'h008, {24'd0, b}, 4'h1);
    end
    rd(11'h004, d); chk("txfull_status", d, st(1'b0, 1'b1));
    wr(11'h000, 32'h0004_0001, 4'hF);
    for (int i = 0; i < 8; i++) begin
      tx_cap(4, b, n);
      chk("tx_byte", {24'd0, b}, {24'd0, tq.pop_front()});
      if (i > 0) chk("tx_b2b_gap", n, 32'd2);
    end
    n = 0;
    repeat (60) begin
      tick();
      if (tx === 1'b0) n++;
    end
    chk("tx_no_dropped_frame", n, 32'd0);
    wr(11'h000, 32'h0004_0008, 4'hF);
    tick(); chk("irq_tx_empty", {31'd0, irq}, 32'd1);
    wr(11'h000, 32'h0000_0001, 4'hF);
    tick(); chk("irq_tx_off", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      tq.push_back(b);
      wr(11'h008, {24'd0, b}, 4'h1);
    end
    for (int i = 0; i < 2; i++) begin
      tx_cap(2, b, n);
      chk("tx_div_clamp_byte", {24'd0, b}, {24'd0, tq.pop_front()});
      if (i > 0) chk("tx_div_clamp_gap", n, 32'd1);
    end
    tick(10);
    lb = 1'b1;
    wr(11'h000, 32'h0004_0007, 4'hF);
    wr(11'h008, 32'h0000_003C, 4'h1);
    chk("lb_irq_low", {31'd0, irq}, 32'd0);
    n = 0;
    while (irq !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("lb_irq_rise", {31'd0, irq}, 32'd1);
    chk("lb_irq_after_frame", {31'd0, n >= 36}, 32'd1);
    rd(11'h00C, d); chk("lb_rxdata", d, 32'h0000013C);
    tick(); chk("lb_irq_fall", {31'd0, irq}, 32'd0);
    rd(11'h004, d); chk("lb_status", d, st(1'b1, 1'b0));
    for (int r = 0; r < 2; r++) begin
      int dv;
      dv = r ? 0 : 3;
      wr(11'h000, {16'(dv), 16'h0007}, 4'hF);
      for (int i = 0; i < 4; i++) begin
        b = 8'($urandom);
        model_rx(b, 1'b1);
        wr(11'h008, {24'd0, b}, 4'h1);
      end
      tick(40 * (dv < 2 ? 2 : dv) + 40);
      for (int i = 0; i < 4; i++) begin
        rd(11'h00C, d); chk("lb_rand_rx", d, {23'd0, 1'b1, rq.pop_front()});
      end
      rd(11'h004, d); chk("lb_rand_status", d, st(1'b1, 1'b0));
    end
    lb = 1'b0;
    rx_drv = 1'b1;
    wr(11'h000, 32'h0004_0002, 4'hF);
    for (int i = 0; i < 9; i++) send_frame(8'($urandom), 1'b1, 4);
    tick(8);
    rd(11'h004, d); chk("ovr_status", d, st(1'b1, 1'b0));
    chk("ovr_irq", {31'd0, irq}, 32'd1);
    wr(11'h004, 32'h0000_0010, 4'h1);
    m_ovr = 1'b0;
    rd(11'h004, d); chk("ovr_clear", d, st(1'b1, 1'b0));
    for (int i = 0; i < 8; i++) begin
      rd(11'h00C, d); chk("ovr_fifo_order", d, {23'd0, 1'b1, rq.pop_front()});
    end
    rd(11'h00C, d); chk("rx_empty_valid", d & 32'h100, 32'd0);
    send_frame(8'h55, 1'b0, 4);
    tick(8);
    rd(11'h004, d); chk("ferr_status", d, st(1'b1, 1'b0));
    wr(11'h004, 32'h0000_0020, 4'h1);
    m_fe = 1'b0;
    rd(11'h004, d); chk("ferr_clear", d, st(1'b1, 1'b0));
    wr(11'h000, 32'h0008_0002, 4'hF);
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    tick(100);
    rd(11'h004, d); chk("glitch_status", d, st(1'b1, 1'b0));
    wr(11'h000, 32'h0004_0001, 4'hF);
    for (int i = 0; i < 2; i++) wr(11'h008, $urandom & 32'hFF, 4'h1);
    tick(10);
    rst = 1'b0;
    tick();
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    rst = 1'b1;
    rd(11'h004, d); chk("midrst_status", d, 32'h0000000A);
    rd(11'h000, d); chk("midrst_ctrl", d, 32'h03640000);
    n = 0;
    repeat (20) begin
      tick();
      if (tx === 1'b0) n++;
    end
    chk("midrst_tx_idle", n, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
